// File: rtl/oflow_core_pkg.sv
// Shared definitions for the oflow frame sequencing core: FSM state encoding and
// default sizing parameters.
package oflow_core_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StDispatch,
    StWaitDone
  } state_e;

  localparam int unsigned DefNumPe      = 8;
  localparam int unsigned DefObjW       = 10;
  localparam int unsigned DefTimeoutCyc = 4096;

endpackage

// File: rtl/oflow_batch_counter.sv
// Tracks the next object index and the objects still to dispatch for the current frame,
// and derives the size of the batch on offer as min(NumPe, remaining).
module oflow_batch_counter
  import oflow_core_pkg::*;
#(
  parameter int unsigned NumPe = DefNumPe,
  parameter int unsigned ObjW  = DefObjW,
  parameter int unsigned SizeW = $clog2(NumPe + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [ObjW-1:0]  count_i,
  input  logic             adv_i,
  output logic [ObjW-1:0]  base_o,
  output logic [SizeW-1:0] size_o,
  output logic             last_o
);

  localparam logic [ObjW-1:0] NumPeObj = ObjW'(NumPe);

  logic [ObjW-1:0] base_q, base_d;
  logic [ObjW-1:0] rem_q, rem_d;
  logic [ObjW-1:0] size_obj;

  assign size_obj = (rem_q >= NumPeObj) ? NumPeObj : rem_q;
  assign size_o   = SizeW'(size_obj);
  assign base_o   = base_q;
  assign last_o   = (rem_q == size_obj);

  always_comb begin
    base_d = base_q;
    rem_d  = rem_q;
    if (load_i) begin
      base_d = '0;
      rem_d  = count_i;
    end else if (adv_i) begin
      base_d = base_q + size_obj;
      rem_d  = rem_q - size_obj;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= '0;
      rem_q  <= '0;
    end else begin
      base_q <= base_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/oflow_frame_sequencer.sv
// Frame sequencer: accepts frame descriptors, pulses start, dispatches objects to the PEs
// in batches and waits for the core. OFLOW_FRAME_TIMEOUT_EN adds a WAIT_DONE watchdog.
module oflow_frame_sequencer
  import oflow_core_pkg::*;
#(
  parameter int unsigned NUM_PE      = DefNumPe,
  parameter int unsigned OBJ_W       = DefObjW,
  parameter int unsigned FRAME_CNT_W = 16,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                         clk,
  input  logic                         reset_N,
  input  logic                         frame_valid,
  input  logic [OBJ_W-1:0]             num_of_objects,
  output logic                         frame_ready,
  output logic                         start,
  output logic                         batch_valid,
  output logic [OBJ_W-1:0]             batch_base,
  output logic [$clog2(NUM_PE+1)-1:0]  batch_size,
  input  logic                         batch_ready,
  input  logic                         core_done,
  output logic                         frame_done,
  output logic [FRAME_CNT_W-1:0]       frame_cnt,
  output logic                         busy,
  output logic                         err_spurious,
  output logic                         err_timeout
);

  localparam int unsigned SizeW = $clog2(NUM_PE + 1);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e                 state_q;
  logic                   frame_done_q;
  logic                   err_spurious_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   accept;
  logic                   adv;
  logic                   last_batch;
  logic                   tmo_hit;

  assign frame_ready  = (state_q == StIdle);
  assign start        = (state_q == StStart);
  assign batch_valid  = (state_q == StDispatch);
  assign busy         = (state_q != StIdle);
  assign frame_done   = frame_done_q;
  assign frame_cnt    = frame_cnt_q;
  assign err_spurious = err_spurious_q;

  assign accept = frame_valid & frame_ready;
  assign adv    = batch_valid & batch_ready;

  oflow_batch_counter #(
    .NumPe (NUM_PE),
    .ObjW  (OBJ_W),
    .SizeW (SizeW)
  ) u_batch_counter (
    .clk_i   (clk),
    .rst_ni  (reset_N),
    .load_i  (accept),
    .count_i (num_of_objects),
    .adv_i   (adv),
    .base_o  (batch_base),
    .size_o  (batch_size),
    .last_o  (last_batch)
  );

`ifdef OFLOW_FRAME_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TmoW-1:0] tmo_q;
  logic            err_timeout_q;

  // Counter is zero on the first WAIT_DONE cycle, so the hit lands TIMEOUT_CYC cycles in.
  assign tmo_hit     = (state_q == StWaitDone) && (tmo_q == TmoW'(TIMEOUT_CYC - 1));
  assign err_timeout = err_timeout_q;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      tmo_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == StWaitDone) ? tmo_q + TmoW'(1) : '0;
      if (tmo_hit && !core_done) begin
        err_timeout_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q        <= StIdle;
      frame_done_q   <= 1'b0;
      frame_cnt_q    <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // Covers a core_done coinciding with the final batch handshake too.
      if (core_done && (state_q != StWaitDone)) begin
        err_spurious_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (num_of_objects == '0) begin
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + FRAME_CNT_W'(1);
            end else begin
              state_q <= StStart;
            end
          end
        end
        StStart: begin
          state_q <= StDispatch;
        end
        StDispatch: begin
          if (adv && last_batch) begin
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (core_done || tmo_hit) begin
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + FRAME_CNT_W'(1);
            state_q      <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/oflow_frame_sequencer.md
OFLOW_FRAME_SEQUENCER -- requirements
Module: oflow_frame_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_PE, default 8, meaning objects dispatched per batch (one per PE).
REQ-002 The block SHALL have parameter OBJ_W, default 10, meaning the width of object counts and indices.
REQ-003 The block SHALL have parameter FRAME_CNT_W, default 16, meaning the width of the frame counter.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 4096, meaning the WAIT_DONE watchdog limit in cycles.
REQ-005 The block SHALL have port clk, input, 1, the single clock.
REQ-006 The block SHALL have port reset_N, input, 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port frame_valid, input, 1, meaning a new frame descriptor is offered.
REQ-008 The block SHALL have port num_of_objects, input, OBJ_W, meaning the object count of the offered frame.
REQ-009 The block SHALL have port frame_ready, output, 1, meaning the descriptor can be accepted.
REQ-010 The block SHALL have port start, output, 1, a one-cycle new-frame pulse to the core.
REQ-011 The block SHALL have port batch_valid, output, 1, meaning a batch is offered to the PEs.
REQ-012 The block SHALL have port batch_base, output, OBJ_W, meaning the first object index of the batch.
REQ-013 The block SHALL have port batch_size, output, $clog2(NUM_PE+1), meaning the objects in the batch (1..NUM_PE).
REQ-014 The block SHALL have port batch_ready, input, 1, meaning the PEs accept the batch.
REQ-015 The block SHALL have port core_done, input, 1, meaning the core finished the frame.
REQ-016 The block SHALL have port frame_done, output, 1, a one-cycle frame-complete pulse.
REQ-017 The block SHALL have port frame_cnt, output, FRAME_CNT_W, meaning frames completed.
REQ-018 The block SHALL have port busy, output, 1, asserted whenever state is not IDLE.
REQ-019 The block SHALL have ports err_spurious and err_timeout, output, 1 each, as sticky error flags.

Function
REQ-020 The FSM SHALL have the states IDLE, START, DISPATCH and WAIT_DONE, all registered.
REQ-021 In IDLE, frame_ready SHALL be 1; in every other state it SHALL be 0.
REQ-022 When frame_valid and frame_ready are both 1, the block SHALL latch num_of_objects into remaining and clear base to 0.
REQ-023 When an accepted frame has num_of_objects of 0, the block SHALL stay in IDLE, pulse frame_done in the next cycle, increment frame_cnt, and issue no start.
REQ-024 When an accepted frame has a non-zero count, the FSM SHALL go to START; start SHALL be 1 for exactly the one START cycle, then the FSM SHALL go to DISPATCH.
REQ-025 In DISPATCH, batch_valid SHALL be 1, batch_base SHALL equal base, and batch_size SHALL equal min(NUM_PE, remaining).
REQ-026 batch_base and batch_size SHALL stay stable while batch_valid is 1 and batch_ready is 0.
REQ-027 On batch_valid and batch_ready both 1, base SHALL increase by batch_size and remaining SHALL decrease by batch_size.
REQ-028 When the final batch is accepted (remaining equals batch_size), the FSM SHALL go to WAIT_DONE; back-to-back batch acceptance SHALL sustain one batch per cycle.
REQ-029 In WAIT_DONE, core_done SHALL cause frame_done to pulse for one cycle, frame_cnt to increment, and the FSM to return to IDLE.
REQ-030 frame_cnt SHALL wrap from all-ones to 0.
REQ-031 core_done in IDLE, START or DISPATCH SHALL be ignored for control and SHALL set err_spurious.
REQ-032 A core_done in the same cycle as the final batch handshake SHALL be treated as spurious.
REQ-033 The minimum new-frame latency SHALL be: descriptor accept to start = 1 cycle, and start to first batch_valid = 1 cycle.

Reset
REQ-034 While reset_N is 0, the block SHALL asynchronously force state to IDLE and all counters to 0.
REQ-035 While reset_N is 0, the outputs SHALL be: start=0, batch_valid=0, batch_base=0, batch_size=0, frame_done=0, frame_cnt=0, busy=0, err_spurious=0, err_timeout=0, frame_ready=1 after deassertion.
REQ-036 A reset mid-frame SHALL abandon the frame without a frame_done pulse.
REQ-037 The error flags SHALL clear only on reset.

Configuration
REQ-038 With OFLOW_FRAME_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT_DONE, cleared on entry.
REQ-039 With OFLOW_FRAME_TIMEOUT_EN defined, reaching TIMEOUT_CYC without core_done SHALL set err_timeout, pulse frame_done, increment frame_cnt, and return the FSM to IDLE.
REQ-040 Without OFLOW_FRAME_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely, no counter logic SHALL exist, and err_timeout SHALL be tied to 0.

Structure
REQ-041 The state enum and the NUM_PE, OBJ_W and TIMEOUT_CYC defaults SHALL live in the shared package oflow_core_pkg.
REQ-042 The block SHALL contain one sub-module, oflow_batch_counter, holding base/remaining and the min() size computation; the FSM SHALL stay in the top module.

Verification
REQ-043 Scenario: num_of_objects=20, NUM_PE=8, batch_ready always 1 -> start pulse, then batches (0,8),(8,8),(16,4) on consecutive cycles, then WAIT_DONE.
REQ-044 Scenario: the same frame with batch_ready low for 3 cycles on the second batch -> (8,8) held stable for 4 cycles, no lost or duplicated objects.
REQ-045 Scenario: num_of_objects=0 -> no start, frame_done one cycle later, frame_cnt=1.
REQ-046 Scenario: core_done pulsed during DISPATCH -> err_spurious=1, FSM still finishes dispatch and waits for a real core_done.
REQ-047 Scenario: OFLOW_FRAME_TIMEOUT_EN defined, TIMEOUT_CYC=16, no core_done -> err_timeout=1 and frame_done 16 cycles after WAIT_DONE entry; without the macro -> busy stays 1.
REQ-048 Scenario: reset_N low during DISPATCH, then frame_cnt preloaded to 0xFFFF and one frame completed -> reset returns to IDLE with all outputs at reset values, and frame_cnt wraps to 0.
